// File: rtl/pipeline_ctrl.sv
// Pipeline control for a five-stage in-order core.
// Tracks what occupies EX, MEM and WB, and from that decides stage enables,
// flushes and bubbles, and the ALU operand forwarding selects. It also holds
// the whole pipeline while a data memory access is outstanding.
module pipeline_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_Rn,
  input  logic [4:0]  id_Rm,
  input  logic [4:0]  id_Rd,
  input  logic        id_usesRn,
  input  logic        id_usesRm,
  input  logic        id_RegWrite,
  input  logic        id_MemRead,
  input  logic        id_MemWrite,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_bubble,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic [1:0]  fwdA,
  output logic [1:0]  fwdB,
  output logic        busy,
  output logic [15:0] stall_cnt
);

  // X31 reads as zero and is never a real producer or consumer of a value.
  localparam logic [4:0] XZR = 5'd31;

  // Forwarding select encodings for the ALU operand muxes.
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef enum logic {
    ST_RUN,
    ST_WAIT
  } state_t;

  // Everything the controller needs to know about an instruction in a stage.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rn;
    logic [4:0] rm;
    logic       uses_rn;
    logic       uses_rm;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
  } slot_t;

  state_t state;
  state_t state_next;

  slot_t ex_slot;
  slot_t mem_slot;
  slot_t wb_slot;
  slot_t id_slot;

  logic mem_access;
  logic freeze;
  logic load_use;
  logic squash_ex;
  logic count_stall;

  // WB only needs valid/rd/reg_write for forwarding; the rest is kept so the
  // slot stays a complete record of the instruction, and is collected here.
  logic unused_wb_fields;

  // Choose the youngest valid producer of a source register. A load in MEM
  // has no data yet (that case is a load-use stall), but its loaded value is
  // on Dw once it reaches WB, so the WB test does not exclude loads.
  function automatic logic [1:0] fwd_select(
    input logic [4:0] src,
    input logic       uses,
    input slot_t      ex_s,
    input slot_t      mem_s,
    input slot_t      wb_s
  );
    logic [1:0] sel;
    sel = FWD_REG;
    if (ex_s.valid && uses) begin
      if (mem_s.valid && mem_s.reg_write && !mem_s.mem_read &&
          (mem_s.rd != XZR) && (mem_s.rd == src)) begin
        sel = FWD_EXMEM;
      end else if (wb_s.valid && wb_s.reg_write &&
                   (wb_s.rd != XZR) && (wb_s.rd == src)) begin
        sel = FWD_MEMWB;
      end
    end
    return sel;
  endfunction

  // Package the ID-stage instruction in slot form so it can drop into EX.
  always_comb begin
    id_slot           = '0;
    id_slot.valid     = id_valid;
    id_slot.rd        = id_Rd;
    id_slot.rn        = id_Rn;
    id_slot.rm        = id_Rm;
    id_slot.uses_rn   = id_usesRn;
    id_slot.uses_rm   = id_usesRm;
    id_slot.reg_write = id_RegWrite;
    id_slot.mem_read  = id_MemRead;
    id_slot.mem_write = id_MemWrite;
  end

  // Hazard detection: memory stall and load-use dependency on the EX load.
  always_comb begin
    mem_access = mem_slot.valid && (mem_slot.mem_read || mem_slot.mem_write);
    freeze     = (state == ST_WAIT) || (mem_access && !mem_ready);
    load_use   = id_valid && ex_slot.valid && ex_slot.mem_read && (ex_slot.rd != XZR) &&
                 ((id_usesRn && (id_Rn == ex_slot.rd)) ||
                  (id_usesRm && (id_Rm == ex_slot.rd)));
    squash_ex   = br_taken || load_use;
    count_stall = freeze || (load_use && !br_taken);
  end

  // State register for the memory-wait FSM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state and stage controls; freeze beats a taken branch, which beats load-use.
  always_comb begin
    state_next  = state;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_bubble = 1'b0;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;

    case (state)
      ST_RUN: begin
        if (mem_access && !mem_ready) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase

    if (reset) begin
      if (freeze) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end else if (br_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  // Advance the tracking slots unless frozen; a squashed ID turns into a bubble in EX.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_slot  <= '0;
      mem_slot <= '0;
      wb_slot  <= '0;
    end else if (!freeze) begin
      wb_slot  <= mem_slot;
      mem_slot <= ex_slot;
      ex_slot  <= squash_ex ? '0 : id_slot;
    end
  end

  // Saturating count of cycles lost to memory freezes and load-use stalls.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= 16'd0;
    end else if (count_stall && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // Operand forwarding selects, forced to the register file while in reset.
  always_comb begin
    fwdA = FWD_REG;
    fwdB = FWD_REG;
    if (reset) begin
      fwdA = fwd_select(ex_slot.rn, ex_slot.uses_rn, ex_slot, mem_slot, wb_slot);
      fwdB = fwd_select(ex_slot.rm, ex_slot.uses_rm, ex_slot, mem_slot, wb_slot);
    end
  end

  assign busy = (state == ST_WAIT);

  assign unused_wb_fields = ^{wb_slot.rn, wb_slot.rm, wb_slot.uses_rn, wb_slot.uses_rm,
                              wb_slot.mem_read, wb_slot.mem_write};

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: random instruction streams checked every cycle
// against a slot-level reference model, plus directed hazard scenarios.
module tb_pipeline_ctrl;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_Rn;
  logic [4:0]  id_Rm;
  logic [4:0]  id_Rd;
  logic        id_usesRn;
  logic        id_usesRm;
  logic        id_RegWrite;
  logic        id_MemRead;
  logic        id_MemWrite;
  logic        br_taken;
  logic        mem_ready;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_en;
  logic        idex_bubble;
  logic        exmem_en;
  logic        memwb_en;
  logic [1:0]  fwdA;
  logic [1:0]  fwdB;
  logic        busy;
  logic [15:0] stall_cnt;

  int check_count = 0;
  int error_count = 0;

  typedef struct {
    bit v;
    int rd;
    int rn;
    int rm;
    bit urn;
    bit urm;
    bit rw;
    bit mr;
    bit mw;
  } mslot_t;

  mslot_t m_ex;
  mslot_t m_mem;
  mslot_t m_wb;
  bit     m_wait;
  int     m_cnt;

  pipeline_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_Rn       (id_Rn),
    .id_Rm       (id_Rm),
    .id_Rd       (id_Rd),
    .id_usesRn   (id_usesRn),
    .id_usesRm   (id_usesRm),
    .id_RegWrite (id_RegWrite),
    .id_MemRead  (id_MemRead),
    .id_MemWrite (id_MemWrite),
    .br_taken    (br_taken),
    .mem_ready   (mem_ready),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .ifid_flush  (ifid_flush),
    .idex_en     (idex_en),
    .idex_bubble (idex_bubble),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .fwdA        (fwdA),
    .fwdB        (fwdB),
    .busy        (busy),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mslot_t empty_slot();
    mslot_t s;
    s.v = 0; s.rd = 0; s.rn = 0; s.rm = 0;
    s.urn = 0; s.urm = 0; s.rw = 0; s.mr = 0; s.mw = 0;
    return s;
  endfunction

  // Youngest valid writer of src wins; a load still in MEM cannot supply data.
  function automatic int exp_fwd(int src, bit uses);
    if (!m_ex.v || !uses) return 0;
    if (m_mem.v && m_mem.rw && !m_mem.mr && m_mem.rd != 31 && m_mem.rd == src) return 2;
    if (m_wb.v && m_wb.rw && m_wb.rd != 31 && m_wb.rd == src) return 1;
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit v, input int rd, input int rn, input int rm,
                               input bit urn, input bit urm, input bit rw, input bit mr,
                               input bit mw, input bit br, input bit rdy);
    logic [31:0] rdv, rnv, rmv;
    rdv = rd; rnv = rn; rmv = rm;
    id_valid    = v;
    id_Rd       = rdv[4:0];
    id_Rn       = rnv[4:0];
    id_Rm       = rmv[4:0];
    id_usesRn   = urn;
    id_usesRm   = urm;
    id_RegWrite = rw;
    id_MemRead  = mr;
    id_MemWrite = mw;
    br_taken    = br;
    mem_ready   = rdy;
  endtask

  // One clock: check outputs at the falling edge, then step the model at the rising edge.
  task automatic run_cycle(input bit chk);
    bit frz, lu;
    bit e_pc, e_ifid, e_flush, e_idex, e_bub, e_exmem, e_memwb;
    int e_fa, e_fb;
    @(negedge clk);
    frz = m_wait || (m_mem.v && (m_mem.mr || m_mem.mw) && !mem_ready);
    lu  = id_valid && m_ex.v && m_ex.mr && m_ex.rd != 31 &&
          ((id_usesRn && id_Rn == m_ex.rd) || (id_usesRm && id_Rm == m_ex.rd));
    e_pc = 1; e_ifid = 1; e_flush = 0; e_idex = 1; e_bub = 0; e_exmem = 1; e_memwb = 1;
    e_fa = 0; e_fb = 0;
    if (reset) begin
      if (frz) begin
        e_pc = 0; e_ifid = 0; e_idex = 0; e_exmem = 0; e_memwb = 0;
      end else if (br_taken) begin
        e_flush = 1; e_bub = 1;
      end else if (lu) begin
        e_pc = 0; e_ifid = 0; e_bub = 1;
      end
      e_fa = exp_fwd(m_ex.rn, m_ex.urn);
      e_fb = exp_fwd(m_ex.rm, m_ex.urm);
    end
    if (chk) begin
      checkOutput("pc_en", pc_en, e_pc);
      checkOutput("ifid_en", ifid_en, e_ifid);
      checkOutput("ifid_flush", ifid_flush, e_flush);
      checkOutput("idex_en", idex_en, e_idex);
      checkOutput("idex_bubble", idex_bubble, e_bub);
      checkOutput("exmem_en", exmem_en, e_exmem);
      checkOutput("memwb_en", memwb_en, e_memwb);
      checkOutput("fwdA", fwdA, e_fa);
      checkOutput("fwdB", fwdB, e_fb);
      checkOutput("busy", busy, m_wait);
      checkOutput("stall_cnt", stall_cnt, m_cnt);
    end
    @(posedge clk);
    if (!reset) begin
      m_ex = empty_slot(); m_mem = empty_slot(); m_wb = empty_slot();
      m_wait = 0; m_cnt = 0;
    end else begin
      if (frz || (lu && !br_taken)) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      if (frz) begin
        m_wait = m_wait ? !mem_ready : 1'b1;
      end else begin
        m_wb  = m_mem;
        m_mem = m_ex;
        if (br_taken || lu) begin
          m_ex = empty_slot();
        end else begin
          m_ex.v = id_valid; m_ex.rd = id_Rd; m_ex.rn = id_Rn; m_ex.rm = id_Rm;
          m_ex.urn = id_usesRn; m_ex.urm = id_usesRm; m_ex.rw = id_RegWrite;
          m_ex.mr = id_MemRead; m_ex.mw = id_MemWrite;
        end
      end
    end
    #1;
  endtask

  task automatic nop_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      run_cycle(1);
    end
  endtask

  function automatic int pick_reg();
    int r;
    r = $urandom_range(0, 9);
    return (r > 7) ? 31 : r;
  endfunction

  initial begin
    int base;
    int guard;
    int kind;
    m_ex = empty_slot(); m_mem = empty_slot(); m_wb = empty_slot();
    m_wait = 0; m_cnt = 0;
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    run_cycle(0);
    run_cycle(1);
    reset = 1'b1;
    nop_cycles(2);

    // Random instruction mix with occasional branches, memory waits and resets.
    for (int n = 0; n < 3000; n++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: applyStimulus(0, pick_reg(), pick_reg(), pick_reg(), 0, 0, 0, 0, 0, 0, 1);
        1: applyStimulus(1, pick_reg(), pick_reg(), pick_reg(), 1, 1, 1, 0, 0, 0, 1);
        2: applyStimulus(1, pick_reg(), pick_reg(), pick_reg(), 1, 0, 1, 1, 0, 0, 1);
        3: applyStimulus(1, pick_reg(), pick_reg(), pick_reg(), 1, 1, 0, 0, 1, 0, 1);
        default: applyStimulus(1, pick_reg(), pick_reg(), pick_reg(), 1, 0, 1, 0, 0, 0, 1);
      endcase
      br_taken  = ($urandom_range(0, 9) == 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 99) != 0);
      run_cycle(1);
    end
    reset = 1'b1;
    nop_cycles(4);

    // Back-to-back ALU dependency forwards from EX/MEM.
    applyStimulus(1, 1, 2, 3, 1, 1, 1, 0, 0, 0, 1); run_cycle(1);
    applyStimulus(1, 2, 1, 3, 1, 1, 1, 0, 0, 0, 1); run_cycle(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
    checkOutput("fwdA_exmem", fwdA, 2'b10);
    checkOutput("fwdB_noneed", fwdB, 2'b00);
    run_cycle(1);
    nop_cycles(3);

    // One NOP between producer and consumer forwards from MEM/WB.
    applyStimulus(1, 1, 2, 3, 1, 1, 1, 0, 0, 0, 1); run_cycle(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); run_cycle(1);
    applyStimulus(1, 2, 1, 3, 1, 1, 1, 0, 0, 0, 1); run_cycle(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
    checkOutput("fwdA_memwb", fwdA, 2'b01);
    run_cycle(1);
    nop_cycles(3);

    // Writes to X31 never forward.
    applyStimulus(1, 31, 2, 3, 1, 1, 1, 0, 0, 0, 1); run_cycle(1);
    applyStimulus(1, 2, 31, 3, 1, 1, 1, 0, 0, 0, 1); run_cycle(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
    checkOutput("fwdA_xzr", fwdA, 2'b00);
    run_cycle(1);
    nop_cycles(3);

    // LDUR X4 then ADD X5,X4,X6: one stall cycle, then forward from MEM/WB.
    base = m_cnt;
    applyStimulus(1, 4, 1, 0, 1, 0, 1, 1, 0, 0, 1); run_cycle(1);
    applyStimulus(1, 5, 4, 6, 1, 1, 1, 0, 0, 0, 1); #1;
    checkOutput("lu_pc_en", pc_en, 1'b0);
    checkOutput("lu_ifid_en", ifid_en, 1'b0);
    checkOutput("lu_bubble", idex_bubble, 1'b1);
    checkOutput("lu_cnt_before", stall_cnt, base);
    run_cycle(1);
    checkOutput("lu_cnt_after", stall_cnt, base + 1);
    checkOutput("lu_released", pc_en, 1'b1);
    run_cycle(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
    checkOutput("lu_fwdA", fwdA, 2'b01);
    checkOutput("lu_cnt_once", stall_cnt, base + 1);
    run_cycle(1);
    nop_cycles(3);

    // A taken branch overrides a simultaneous load-use and is not counted.
    base = m_cnt;
    applyStimulus(1, 4, 1, 0, 1, 0, 1, 1, 0, 0, 1); run_cycle(1);
    applyStimulus(1, 5, 4, 6, 1, 1, 1, 0, 0, 1, 1); #1;
    checkOutput("br_flush", ifid_flush, 1'b1);
    checkOutput("br_bubble", idex_bubble, 1'b1);
    checkOutput("br_pc_en", pc_en, 1'b1);
    run_cycle(1);
    checkOutput("br_cnt", stall_cnt, base);
    nop_cycles(3);

    // STUR waits three cycles in MEM: four frozen cycles, three of them busy.
    base = m_cnt;
    applyStimulus(1, 0, 1, 4, 1, 1, 0, 0, 1, 0, 1); run_cycle(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); run_cycle(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    checkOutput("st_freeze1", pc_en, 1'b0);
    checkOutput("st_busy1", busy, 1'b0);
    run_cycle(1);
    for (int i = 0; i < 2; i++) begin
      checkOutput("st_busy", busy, 1'b1);
      checkOutput("st_freeze", memwb_en, 1'b0);
      run_cycle(1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
    checkOutput("st_busy_last", busy, 1'b1);
    checkOutput("st_freeze_last", pc_en, 1'b0);
    run_cycle(1);
    checkOutput("st_busy_done", busy, 1'b0);
    checkOutput("st_cnt", stall_cnt, base + 4);
    checkOutput("st_resume", pc_en, 1'b1);
    nop_cycles(3);

    // Reset in the middle of a memory wait.
    applyStimulus(1, 0, 1, 4, 1, 1, 0, 0, 1, 0, 1); run_cycle(1);
    applyStimulus(1, 7, 4, 4, 1, 1, 1, 0, 0, 0, 1); run_cycle(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); run_cycle(1);
    checkOutput("rw_busy_pre", busy, 1'b1);
    reset = 1'b0; #1;
    checkOutput("rw_pc_en_in_reset", pc_en, 1'b1);
    run_cycle(1);
    checkOutput("rw_busy", busy, 1'b0);
    checkOutput("rw_cnt", stall_cnt, 16'd0);
    checkOutput("rw_enables", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 5'b11111);
    checkOutput("rw_fwd", {fwdA, fwdB}, 4'b0000);
    reset = 1'b1;
    nop_cycles(3);

    // Drive the stall counter to saturation with a long memory wait.
    applyStimulus(1, 0, 1, 4, 1, 1, 0, 0, 1, 0, 1); run_cycle(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); run_cycle(1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    guard = 0;
    while (m_cnt < 65535 && guard < 70000) begin
      run_cycle(0);
      guard++;
    end
    checkOutput("sat_reached", stall_cnt, 16'hFFFF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    run_cycle(1);
    checkOutput("sat_hold_freeze", stall_cnt, 16'hFFFF);
    nop_cycles(3);
    applyStimulus(1, 4, 1, 0, 1, 0, 1, 1, 0, 0, 1); run_cycle(1);
    applyStimulus(1, 5, 4, 6, 1, 1, 1, 0, 0, 0, 1); run_cycle(1);
    checkOutput("sat_hold_lu", stall_cnt, 16'hFFFF);
    nop_cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
